// File: rtl/elevator_car_ctrl.sv
// Elevator car motion/door controller.
// Latches the encoded floor request as the target, steps the car one floor
// every TRAVEL_CYCLES clocks, then holds the door open for DOOR_CYCLES clocks.
// On arrival it emits a one-cycle arrived pulse and a one-hot served pulse.
// Optional feature macro: ELEV_DOOR_HOLD_EN. When it is defined, door_hold
// restarts the door timer while the door is open.
module elevator_car_ctrl #(
  parameter int unsigned NUM_FLOORS    = 8,
  parameter int unsigned FLOOR_W       = 3,
  parameter int unsigned TRAVEL_CYCLES = 4,
  parameter int unsigned DOOR_CYCLES   = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic [FLOOR_W-1:0]    req_floor,
  input  logic                  door_hold,
  output logic [FLOOR_W-1:0]    cur_floor,
  output logic                  move_up,
  output logic                  move_down,
  output logic                  door_open,
  output logic                  busy,
  output logic                  arrived,
  output logic [NUM_FLOORS-1:0] served
);

  localparam int unsigned TCW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
  localparam int unsigned DCW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;

  localparam logic [TCW-1:0]     TRAVEL_LAST = TCW'(TRAVEL_CYCLES - 1);
  localparam logic [DCW-1:0]     DOOR_LAST   = DCW'(DOOR_CYCLES - 1);
  localparam logic [FLOOR_W:0]   FLOOR_LIMIT = (FLOOR_W + 1)'(NUM_FLOORS);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_MOVE_UP   = 2'd1,
    ST_MOVE_DOWN = 2'd2,
    ST_DOOR_OPEN = 2'd3
  } state_e;

  state_e                  state_q,      state_d;
  logic [FLOOR_W-1:0]      cur_floor_q,  cur_floor_d;
  logic [FLOOR_W-1:0]      target_q,     target_d;
  logic [TCW-1:0]          travel_cnt_q, travel_cnt_d;
  logic [DCW-1:0]          door_cnt_q,   door_cnt_d;
  logic                    arrived_q,    arrived_d;
  logic [NUM_FLOORS-1:0]   served_q,     served_d;

  logic                    req_in_range;
  logic [FLOOR_W-1:0]      floor_above;
  logic [FLOOR_W-1:0]      floor_below;
  logic                    travel_done;
  logic                    door_done;
  logic                    door_restart;

`ifdef ELEV_DOOR_HOLD_EN
  assign door_restart = door_hold;
`else
  // door_hold is kept on the port list so both builds share one footprint.
  logic door_hold_unused;
  assign door_hold_unused = door_hold;
  assign door_restart     = 1'b0;
`endif

  // Requests for floors outside the served range are dropped in IDLE.
  assign req_in_range = ({1'b0, req_floor} < FLOOR_LIMIT);
  assign floor_above  = cur_floor_q + FLOOR_W'(1);
  assign floor_below  = cur_floor_q - FLOOR_W'(1);
  assign travel_done  = (travel_cnt_q == TRAVEL_LAST);
  assign door_done    = (door_cnt_q == DOOR_LAST);

  function automatic logic [NUM_FLOORS-1:0] floor_onehot(input logic [FLOOR_W-1:0] f);
    logic [NUM_FLOORS-1:0] oh;
    oh = '0;
    for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
      oh[i] = (FLOOR_W'(i) == f);
    end
    return oh;
  endfunction

  // State, position, target, counters and arrival pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cur_floor_q  <= '0;
      target_q     <= '0;
      travel_cnt_q <= '0;
      door_cnt_q   <= '0;
      arrived_q    <= 1'b0;
      served_q     <= '0;
    end else begin
      state_q      <= state_d;
      cur_floor_q  <= cur_floor_d;
      target_q     <= target_d;
      travel_cnt_q <= travel_cnt_d;
      door_cnt_q   <= door_cnt_d;
      arrived_q    <= arrived_d;
      served_q     <= served_d;
    end
  end

  // Next-state logic: request capture, floor stepping, door timing.
  always_comb begin
    state_d      = state_q;
    cur_floor_d  = cur_floor_q;
    target_d     = target_q;
    travel_cnt_d = travel_cnt_q;
    door_cnt_d   = door_cnt_q;
    arrived_d    = 1'b0;
    served_d     = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid && req_in_range) begin
          target_d     = req_floor;
          travel_cnt_d = '0;
          door_cnt_d   = '0;
          if (req_floor > cur_floor_q) begin
            state_d = ST_MOVE_UP;
          end else if (req_floor < cur_floor_q) begin
            state_d = ST_MOVE_DOWN;
          end else begin
            // Already at the requested floor: open the door straight away.
            state_d   = ST_DOOR_OPEN;
            arrived_d = 1'b1;
            served_d  = floor_onehot(req_floor);
          end
        end
      end

      ST_MOVE_UP: begin
        if (travel_done) begin
          travel_cnt_d = '0;
          cur_floor_d  = floor_above;
          if (floor_above == target_q) begin
            state_d    = ST_DOOR_OPEN;
            door_cnt_d = '0;
            arrived_d  = 1'b1;
            served_d   = floor_onehot(target_q);
          end
        end else begin
          travel_cnt_d = travel_cnt_q + TCW'(1);
        end
      end

      ST_MOVE_DOWN: begin
        if (travel_done) begin
          travel_cnt_d = '0;
          cur_floor_d  = floor_below;
          if (floor_below == target_q) begin
            state_d    = ST_DOOR_OPEN;
            door_cnt_d = '0;
            arrived_d  = 1'b1;
            served_d   = floor_onehot(target_q);
          end
        end else begin
          travel_cnt_d = travel_cnt_q + TCW'(1);
        end
      end

      ST_DOOR_OPEN: begin
        if (door_restart) begin
          door_cnt_d = '0;
        end else if (door_done) begin
          door_cnt_d = '0;
          state_d    = ST_IDLE;
        end else begin
          door_cnt_d = door_cnt_q + DCW'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign cur_floor = cur_floor_q;
  assign move_up   = (state_q == ST_MOVE_UP);
  assign move_down = (state_q == ST_MOVE_DOWN);
  assign door_open = (state_q == ST_DOOR_OPEN);
  assign busy      = (state_q != ST_IDLE);
  assign arrived   = arrived_q;
  assign served    = served_q;

endmodule

// File: tb/tb_elevator_car_ctrl.sv
// Self-checking bench for elevator_car_ctrl.
// The reference model is a trip timeline: for a request of distance N floors
// sampled at edge E0, the car is moving for N*TRAVEL_CYCLES edges, then the
// door is open until DOOR_CYCLES edges after the later of arrival and the
// last honoured door_hold, then idle.
module tb_elevator_car_ctrl;

  localparam int NF = 8;
  localparam int FW = 3;
  localparam int TC = 4;
  localparam int DC = 6;

`ifdef ELEV_DOOR_HOLD_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic [FW-1:0] req_floor;
  logic          door_hold;
  logic [FW-1:0] cur_floor;
  logic          move_up, move_down, door_open, busy, arrived;
  logic [NF-1:0] served;

  // Second instance: 6 floors, so floor indices 6 and 7 are out of range.
  logic          req_valid2;
  logic [2:0]    req_floor2;
  logic [2:0]    cur_floor2;
  logic          move_up2, move_down2, door_open2, busy2, arrived2;
  logic [5:0]    served2;

  int n_tests = 0;
  int n_fail  = 0;
  int f_model = 0;

  always #5 clk = ~clk;

  elevator_car_ctrl #(
    .NUM_FLOORS(NF), .FLOOR_W(FW), .TRAVEL_CYCLES(TC), .DOOR_CYCLES(DC)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_floor(req_floor),
    .door_hold(door_hold), .cur_floor(cur_floor), .move_up(move_up),
    .move_down(move_down), .door_open(door_open), .busy(busy),
    .arrived(arrived), .served(served)
  );

  elevator_car_ctrl #(
    .NUM_FLOORS(6), .FLOOR_W(3), .TRAVEL_CYCLES(2), .DOOR_CYCLES(3)
  ) dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid2), .req_floor(req_floor2),
    .door_hold(1'b0), .cur_floor(cur_floor2), .move_up(move_up2),
    .move_down(move_down2), .door_open(door_open2), .busy(busy2),
    .arrived(arrived2), .served(served2)
  );

  logic [15:0] obs1, obs2;
  assign obs1 = {cur_floor, move_up, move_down, door_open, busy, arrived, served};
  assign obs2 = {2'b00, cur_floor2, move_up2, move_down2, door_open2, busy2, arrived2, served2};

  // Packed expectation: {cur, up, down, door, busy, arrived, served}.
  function automatic logic [15:0] expv(input int cur, input bit up, input bit dn,
                                       input bit door, input int srv_floor);
    logic [NF-1:0] s;
    logic [FW-1:0] c;
    s = '0;
    if (srv_floor >= 0) s[srv_floor] = 1'b1;
    c = FW'(cur);
    return {c, up, dn, door, (up | dn | door), (srv_floor >= 0), s};
  endfunction

  function automatic logic [15:0] expv2(input int cur, input bit up, input bit dn,
                                        input bit door, input int srv_floor);
    logic [5:0] s;
    logic [2:0] c;
    s = '0;
    if (srv_floor >= 0) s[srv_floor] = 1'b1;
    c = 3'(cur);
    return {2'b00, c, up, dn, door, (up | dn | door), (srv_floor >= 0), s};
  endfunction

  task automatic check(input string tag, input logic [15:0] o, input logic [15:0] e);
    n_tests++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One trip from f_model to r. hold_rand: random door_hold each cycle;
  // otherwise door_hold is high for door cycles [hs, hs+hl). abort_k >= 0
  // applies a reset after the check at edge E0+abort_k.
  task automatic do_trip(input int r, input bit hold_rand, input int hs,
                         input int hl, input int abort_k, input string tag);
    int n, m, last, dir;
    bit prev_hold, in_door_before;
    logic [15:0] e;
    n    = (r > f_model) ? (r - f_model) : (f_model - r);
    dir  = (r > f_model) ? 1 : -1;
    m    = n * TC;
    last = m;
    req_valid = 1'b1;
    req_floor = FW'(r);
    door_hold = 1'b0;
    prev_hold = 1'b0;
    tick();
    for (int k = 0; k < 2000; k++) begin
      in_door_before = (k - 1 >= m) && (k - 1 < last + DC);
      if (HOLD_EN && prev_hold && in_door_before) last = k;
      if (k < m)
        e = expv(f_model + dir * (k / TC), dir > 0, dir < 0, 1'b0, -1);
      else if (k < last + DC)
        e = expv(r, 1'b0, 1'b0, 1'b1, (k == m) ? r : -1);
      else
        e = expv(r, 1'b0, 1'b0, 1'b0, -1);
      check(tag, obs1, e);
      if (k == abort_k) begin
        rst = 1'b1;
        req_valid = 1'b0;
        door_hold = 1'b0;
        tick();
        check({tag, "_reset"}, obs1, expv(0, 1'b0, 1'b0, 1'b0, -1));
        rst = 1'b0;
        f_model = 0;
        return;
      end
      if (k >= last + DC) break;
      // Requests and junk floors while busy must be ignored.
      req_valid = 1'($urandom_range(0, 1));
      req_floor = FW'($urandom_range(0, NF - 1));
      if (hold_rand)
        door_hold = ($urandom_range(0, 3) == 0);
      else
        door_hold = (k - m >= hs) && (k - m < hs + hl);
      prev_hold = door_hold;
      tick();
    end
    req_valid = 1'b0;
    door_hold = 1'b0;
    f_model = r;
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b1;
    req_floor  = 3'd5;
    door_hold  = 1'b0;
    req_valid2 = 1'b1;
    req_floor2 = 3'd5;
    tick();
    tick();
    check("reset", obs1, expv(0, 1'b0, 1'b0, 1'b0, -1));
    check("reset2", obs2, expv2(0, 1'b0, 1'b0, 1'b0, -1));
    rst       = 1'b0;
    req_valid = 1'b0;

    // Out-of-range requests on the 6-floor instance are dropped.
    req_floor2 = 3'd7;
    tick();
    check("oor7", obs2, expv2(0, 1'b0, 1'b0, 1'b0, -1));
    req_floor2 = 3'd6;
    tick();
    check("oor6", obs2, expv2(0, 1'b0, 1'b0, 1'b0, -1));
    req_floor2 = 3'd5;
    tick();
    req_valid2 = 1'b0;
    for (int i = 1; i <= 9; i++) tick();
    check("top_move", obs2, expv2(4, 1'b1, 1'b0, 1'b0, -1));
    tick();
    check("top_arrive", obs2, expv2(5, 1'b0, 1'b0, 1'b1, 5));
    for (int i = 0; i < 3; i++) tick();
    check("top_idle", obs2, expv2(5, 1'b0, 1'b0, 1'b0, -1));

    do_trip(3, 1'b0, 0, 0, -1, "up_0_3");
    do_trip(1, 1'b0, 0, 0, -1, "down_3_1");
    do_trip(2, 1'b0, 0, 0, -1, "up_1_2");
    do_trip(2, 1'b0, 0, 0, -1, "same_2");
    do_trip(0, 1'b0, 0, 0, -1, "down_2_0");
    do_trip(6, 1'b0, 0, 0, -1, "ignore_mid");
    do_trip(2, 1'b0, 4, 3, -1, "door_hold");
    do_trip(4, 1'b0, 0, 0, 2 * TC + 2, "rst_door");
    do_trip(5, 1'b0, 0, 0, 5, "rst_move");
    do_trip(7, 1'b0, 0, 0, -1, "up_0_7");
    do_trip(0, 1'b0, 0, 0, -1, "down_7_0");

    for (int t = 0; t < 40; t++) begin
      do_trip($urandom_range(0, NF - 1), 1'b1, 0, 0, -1, "rand");
      for (int i = 0; i < $urandom_range(0, 2); i++) begin
        tick();
        check("idle", obs1, expv(f_model, 1'b0, 1'b0, 1'b0, -1));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
